// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard beside ID: per-register countdowns until a write becomes
// forwardable, plus an MDU busy countdown; raises stall on load-use and MDU-busy hazards.
module hazard_scoreboard #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MUL_LAT  = 4,
  parameter int unsigned DIV_LAT  = 32,
  parameter int unsigned CNT_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_RegWrite,
  input  logic        id_MemtoReg,
  input  logic        id_mdu_op,
  input  logic        id_mdu_start,
  input  logic        id_is_div,
  input  logic        ex_flush,
  output logic        stall,
  output logic        issue,
  output logic [31:0] pending,
  output logic        mdu_busy
);

  logic [CNT_W-1:0] cnt_q [1:31];
  logic [CNT_W-1:0] cnt_d [1:31];
  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic             raw_hz, mdu_hz;

  always_comb begin
    pending = '0;
    for (int r = 1; r < 32; r++) begin
      pending[r] = (cnt_q[r] != '0);
    end
    mdu_busy = (mdu_cnt_q != '0);
    raw_hz   = id_valid & ((id_use_rs & pending[id_rs]) | (id_use_rt & pending[id_rt]));
    mdu_hz   = id_valid & id_mdu_op & mdu_busy;
    // A squashed instruction must never hold the front end.
    stall    = (raw_hz | mdu_hz) & ~ex_flush;
    issue    = id_valid & ~stall & ~ex_flush;
  end

  always_comb begin
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
      // A younger ALU write forwards from EX_MEM, so it cancels an older load entry.
      if (issue && id_RegWrite && (id_rd == 5'(r))) begin
        cnt_d[r] = id_MemtoReg ? CNT_W'(LOAD_LAT) : '0;
      end
    end
    mdu_cnt_d = (mdu_cnt_q != '0) ? mdu_cnt_q - 1'b1 : '0;
    if (issue && id_mdu_start) begin
      mdu_cnt_d = id_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      mdu_cnt_q <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against a model that
// tracks the absolute cycle at which each register / the MDU becomes available.
module tb_hazard_scoreboard;

  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 4;
  localparam int DIV_LAT  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic        id_RegWrite = 1'b0, id_MemtoReg = 1'b0;
  logic        id_mdu_op = 1'b0, id_mdu_start = 1'b0, id_is_div = 1'b0;
  logic        ex_flush = 1'b0;
  logic        stall, issue, mdu_busy;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  longint now = 0;
  longint ready [32];
  longint mdu_ready = 0;
  logic   last_stall, last_issue;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_RegWrite(id_RegWrite),
    .id_MemtoReg(id_MemtoReg), .id_mdu_op(id_mdu_op), .id_mdu_start(id_mdu_start),
    .id_is_div(id_is_div), .ex_flush(ex_flush), .stall(stall), .issue(issue),
    .pending(pending), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) ready[r] = 0;
    mdu_ready = 0;
  endtask

  task automatic set_ins(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mtr, input logic mop, input logic mst,
                         input logic dv, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_rd = rd;
    id_RegWrite = rw; id_MemtoReg = mtr; id_mdu_op = mop; id_mdu_start = mst;
    id_is_div = dv; ex_flush = fl;
  endtask

  task automatic lw(input logic [4:0] rd, input logic [4:0] rs);
    set_ins(1, rs, 0, 1, 0, rd, 1, 1, 0, 0, 0, 0);
  endtask
  task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    set_ins(1, rs, rt, 1, 1, rd, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic mdu(input logic start, input logic dv, input logic [4:0] rd, input logic rw);
    set_ins(1, 1, 2, start, start, rd, rw, 0, 1, start, dv, 0);
  endtask
  task automatic nop();
    set_ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic bubble();
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check outputs against the model at negedge, advance the model at posedge.
  task automatic cycle();
    logic [31:0] pm;
    logic        bm, raw, sm, im;
    @(negedge clk);
    pm = '0;
    for (int r = 1; r < 32; r++) pm[r] = (now < ready[r]);
    bm  = (now < mdu_ready);
    raw = id_valid & ((id_use_rs & pm[id_rs]) | (id_use_rt & pm[id_rt]));
    sm  = (raw | (id_valid & id_mdu_op & bm)) & ~ex_flush;
    im  = id_valid & ~sm & ~ex_flush;
    chk("pending", pending, pm);
    chk("mdu_busy", 32'(mdu_busy), 32'(bm));
    chk("stall", 32'(stall), 32'(sm));
    chk("issue", 32'(issue), 32'(im));
    last_stall = stall;
    last_issue = issue;
    @(posedge clk);
    if (im) begin
      if (id_RegWrite && id_rd != 0) ready[id_rd] = id_MemtoReg ? now + 1 + LOAD_LAT : 0;
      if (id_mdu_start) mdu_ready = now + 1 + (id_is_div ? DIV_LAT : MUL_LAT);
    end
    now++;
    #1;
  endtask

  task automatic run_until_issue(input string tag, input int exp_stalls);
    int  stalls = 0;
    bit  done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      cycle();
      if (last_issue) done = 1;
      else if (last_stall) stalls++;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no-issue expected=issue", tag);
    end
    chk(tag, stalls, exp_stalls);
    bubble();
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_issue", 32'(issue), 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", 32'(mdu_busy), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // Load-use: one stall cycle.
    lw(5, 1); cycle();
    alu(6, 5, 1); run_until_issue("t1_stalls", LOAD_LAT);
    // Load then independent consumer.
    lw(5, 1); cycle();
    alu(6, 1, 2); run_until_issue("t2_stalls", 0);
    // Load to r0 never creates a hazard.
    lw(0, 1); cycle();
    alu(6, 0, 0); run_until_issue("t3_stalls", 0);
    // div, one unrelated instruction, then mflo.
    mdu(1, 1, 0, 0); cycle();
    nop(); cycle();
    mdu(0, 0, 8, 1); run_until_issue("t4_div_stalls", DIV_LAT - 1);
    mdu(1, 0, 0, 0); cycle();
    nop(); cycle();
    mdu(0, 0, 9, 1); run_until_issue("t4_mul_stalls", MUL_LAT - 1);
    // Flush wins over a load-use stall.
    lw(5, 1); cycle();
    alu(6, 5, 1); ex_flush = 1'b1; cycle();
    chk("t5_stall", 32'(last_stall), 0);
    chk("t5_issue", 32'(last_issue), 0);
    bubble(); cycle();
    chk("t5_pending5", 32'(pending[5]), 0);
    // WAW: ALU write cancels pending load.
    lw(5, 1); cycle();
    alu(5, 1, 2); cycle();
    alu(6, 5, 1); run_until_issue("t6_waw_stalls", 0);
    // Asynchronous reset in the middle of a divide.
    mdu(1, 1, 0, 0); cycle();
    bubble(); cycle(); cycle(); cycle();
    lw(7, 1); cycle();
    mdu(0, 0, 8, 1);
    #1 chk("pre_rst_stall", 32'(stall), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(mdu_busy), 0);
    chk("async_rst_pending", pending, 0);
    chk("async_rst_stall", 32'(stall), 0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    cycle();
    bubble();

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      logic rw, mop;
      rw  = 1'($urandom_range(0, 1));
      mop = ($urandom_range(0, 5) == 0);
      set_ins(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              rw, rw & ($urandom_range(0, 2) == 0), mop, mop & 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
